// File: rtl/dm_port_arbiter_pkg.sv
// Shared constants for the data-memory port arbiter.
// Memory op encodings and arbiter state codes.
package dm_port_arbiter_pkg;

  localparam int DM_ADDR_BIT = 32;
  localparam int DM_OP_BIT   = 3;
  localparam int BEAT_BIT    = 4;

  localparam logic [DM_OP_BIT-1:0] DM_OP_WD = 3'b010;

  localparam int ARB_STATE_BIT = 1;
  localparam logic [ARB_STATE_BIT-1:0] ARB_CPU = 1'b0;
  localparam logic [ARB_STATE_BIT-1:0] ARB_DMA = 1'b1;

  function automatic logic [BEAT_BIT+1:0] beat_ofs(
    input logic [BEAT_BIT-1:0] beat
  );
    return {beat, 2'b00};
  endfunction

endpackage

// File: rtl/dm_port_arbiter_if.sv
// CPU, DMA and data-memory signal bundle around the arbiter.
// slave = arbiter view, master = surrounding logic view.
interface dm_port_arbiter_if
  import dm_port_arbiter_pkg::*;
#(
  parameter int ADDR_BIT = DM_ADDR_BIT
) ();

  logic                 cpu_valid;
  logic                 cpu_w_en;
  logic [DM_OP_BIT-1:0] cpu_op;
  logic [ADDR_BIT-1:0]  cpu_addr;
  logic [31:0]          cpu_wdata;
  logic [31:0]          cpu_rdata;
  logic                 cpu_stall;

  logic                 dma_req;
  logic                 dma_we;
  logic [ADDR_BIT-1:0]  dma_addr;
  logic [BEAT_BIT-1:0]  dma_len;
  logic                 dma_gnt;
  logic [31:0]          dma_wdata;
  logic                 dma_wready;
  logic [31:0]          dma_rdata;
  logic                 dma_rvalid;
  logic                 dma_done;

  logic [DM_OP_BIT-1:0] mem_op;
  logic                 mem_w_en;
  logic [ADDR_BIT-1:0]  mem_addr;
  logic [31:0]          mem_wdata;
  logic [31:0]          mem_rdata;

  modport slave (
    input  cpu_valid, cpu_w_en, cpu_op,
    input  cpu_addr, cpu_wdata,
    output cpu_rdata, cpu_stall,
    input  dma_req, dma_we, dma_addr,
    input  dma_len, dma_wdata,
    output dma_gnt, dma_wready, dma_rdata,
    output dma_rvalid, dma_done,
    output mem_op, mem_w_en, mem_addr,
    output mem_wdata,
    input  mem_rdata
  );

  modport master (
    output cpu_valid, cpu_w_en, cpu_op,
    output cpu_addr, cpu_wdata,
    input  cpu_rdata, cpu_stall,
    output dma_req, dma_we, dma_addr,
    output dma_len, dma_wdata,
    input  dma_gnt, dma_wready, dma_rdata,
    input  dma_rvalid, dma_done,
    input  mem_op, mem_w_en, mem_addr,
    input  mem_wdata,
    output mem_rdata
  );

endinterface

// File: rtl/dm_port_arbiter_burst.sv
// Burst beat counter: latches base/length at grant and
// produces the current beat address and last-beat flag.
module SynBurstCounter
  import dm_port_arbiter_pkg::*;
#(
  parameter int ADDR_BIT = DM_ADDR_BIT
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                load,
  input  logic                step,
  input  logic [ADDR_BIT-1:0] load_base,
  input  logic [BEAT_BIT-1:0] load_last,
  output logic [ADDR_BIT-1:0] addr,
  output logic                is_last
);

  logic [BEAT_BIT-1:0] beat;
  logic [BEAT_BIT-1:0] last;
  logic [ADDR_BIT-1:0] base;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      beat <= '0;
      last <= '0;
      base <= '0;
    end else if (load) begin
      base <= load_base;
      last <= load_last;
      beat <= '0;
    end else if (step) begin
      beat <= beat + BEAT_BIT'(1);
    end
  end

  // address wraps modulo the memory size
  assign addr    = base + ADDR_BIT'(beat_ofs(beat));
  assign is_last = beat == last;

endmodule

// File: rtl/dm_port_arbiter.sv
// Shares the data memory port between the DM stage and a
// DMA/debug burst requester; CPU owns the port by default.
module dm_port_arbiter
  import dm_port_arbiter_pkg::*;
#(
  parameter int ADDR_BIT = DM_ADDR_BIT,
  parameter int MAX_WAIT = 4
) (
  input logic             clk,
  input logic             rst,
  input logic             en,
  dm_port_arbiter_if.slave bus
);

  logic [ARB_STATE_BIT-1:0] state;
  logic [3:0]               wait_cnt;
  logic                     dir;
  logic                     act;
  logic                     in_dma;
  logic                     starved;
  logic                     grant;
  logic                     is_last;
  logic [ADDR_BIT-1:0]      burst_addr;

  assign act     = en & ~rst;
  assign in_dma  = state == ARB_DMA;
  assign starved = wait_cnt == 4'(MAX_WAIT);
  assign grant   = act & ~in_dma & bus.dma_req
                 & (~bus.cpu_valid | starved);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ARB_CPU;
      wait_cnt <= '0;
      dir      <= 1'b0;
    end else if (en) begin
      unique case (1'b1)
        in_dma: if (is_last) state <= ARB_CPU;
        grant: begin
          state <= ARB_DMA;
          dir   <= bus.dma_we;
        end
        default: ;
      endcase
      if (grant || !bus.dma_req)
        wait_cnt <= '0;
      else if (!in_dma && bus.cpu_valid && !starved)
        wait_cnt <= wait_cnt + 4'd1;
    end
  end

  SynBurstCounter #(
    .ADDR_BIT (ADDR_BIT)
  ) u_burst (
    .clk       (clk),
    .rst       (rst),
    .load      (grant),
    .step      (act & in_dma),
    .load_base (bus.dma_addr),
    .load_last (bus.dma_len),
    .addr      (burst_addr),
    .is_last   (is_last)
  );

  always_comb begin
    bus.mem_op    = bus.cpu_op;
    bus.mem_addr  = bus.cpu_addr;
    bus.mem_wdata = bus.cpu_wdata;
    bus.mem_w_en  = act & bus.cpu_valid & bus.cpu_w_en;
    if (in_dma) begin
      bus.mem_op    = DM_OP_WD;
      bus.mem_addr  = burst_addr;
      bus.mem_wdata = bus.dma_wdata;
      bus.mem_w_en  = act & dir;
    end
  end

  assign bus.cpu_rdata  = bus.mem_rdata;
  assign bus.cpu_stall  = in_dma & bus.cpu_valid;
  assign bus.dma_gnt    = grant;
  assign bus.dma_wready = act & in_dma & dir;
  assign bus.dma_rvalid = act & in_dma & ~dir;
  assign bus.dma_rdata  = bus.mem_rdata;
  assign bus.dma_done   = act & in_dma & is_last;

endmodule

// File: tb/tb_dm_port_arbiter.sv
// Self-checking bench for dm_port_arbiter: table vectors,
// directed corner sequences and random traffic vs a model.
module tb_dm_port_arbiter;
  import dm_port_arbiter_pkg::*;

  localparam int AW = 10;
  localparam int MW = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic en  = 1'b1;

  always #5 clk = ~clk;

  dm_port_arbiter_if #(.ADDR_BIT(AW)) bus ();

  dm_port_arbiter #(
    .ADDR_BIT (AW),
    .MAX_WAIT (MW)
  ) dut (
    .clk (clk),
    .rst (rst),
    .en  (en),
    .bus (bus)
  );

  logic [31:0] mem [256];
  assign bus.mem_rdata = mem[bus.mem_addr[9:2]];

  int passed = 0;
  int total  = 0;

  logic [9:0] q [$];
  bit         m_dir;
  int         starve;

  logic       o_gnt, o_stall, o_done;
  logic       o_wen, o_rvalid;
  logic [9:0] o_addr;
  logic [31:0] o_rdata, o_drdata;

  task automatic chk(input string name,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h",
                  name, act, exp);
  endtask

  task automatic step();
    logic busy;
    logic [50:0] e, a;
    logic [9:0] ea, wa;
    logic wr;
    logic [31:0] wd;
    @(negedge clk);
    busy = q.size() != 0;
    if (busy) begin
      ea = q[0];
      e = {1'b0, bus.cpu_valid, en && q.size() == 1,
           en && m_dir, en && m_dir, en && !m_dir,
           DM_OP_WD, ea, bus.dma_wdata};
    end else begin
      ea = bus.cpu_addr;
      e = {en && bus.dma_req &&
             (!bus.cpu_valid || starve == MW),
           1'b0, 1'b0,
           en && bus.cpu_valid && bus.cpu_w_en,
           1'b0, 1'b0, bus.cpu_op, ea, bus.cpu_wdata};
    end
    a = {bus.dma_gnt, bus.cpu_stall, bus.dma_done,
         bus.mem_w_en, bus.dma_wready, bus.dma_rvalid,
         bus.mem_op, bus.mem_addr, bus.mem_wdata};
    chk("model", 64'(a), 64'(e));
    chk("rdata", {bus.cpu_rdata, bus.dma_rdata},
        {mem[ea[9:2]], mem[ea[9:2]]});
    o_gnt    = bus.dma_gnt;
    o_stall  = bus.cpu_stall;
    o_done   = bus.dma_done;
    o_wen    = bus.mem_w_en;
    o_rvalid = bus.dma_rvalid;
    o_addr   = bus.mem_addr;
    o_rdata  = bus.cpu_rdata;
    o_drdata = bus.dma_rdata;
    if (en) begin
      if (busy) begin
        void'(q.pop_front());
        if (!bus.dma_req) starve = 0;
      end else if (e[50]) begin
        m_dir = bus.dma_we;
        for (int i = 0; i <= int'(bus.dma_len); i++)
          q.push_back(
            10'((int'(bus.dma_addr) + 4 * i) % 1024));
        starve = 0;
      end else if (!bus.dma_req) begin
        starve = 0;
      end else if (bus.cpu_valid && starve < MW) begin
        starve++;
      end
    end
    wr = bus.mem_w_en;
    wa = bus.mem_addr;
    wd = bus.mem_wdata;
    @(posedge clk);
    if (wr) mem[wa[9:2]] = wd;
    #1;
  endtask

  task automatic set_cpu(input logic v, input logic w,
                         input logic [9:0] ad);
    bus.cpu_valid = v;
    bus.cpu_w_en  = w;
    bus.cpu_addr  = ad;
  endtask

  task automatic set_dma(input logic r, input logic w,
                         input logic [9:0] ad,
                         input logic [3:0] l);
    bus.dma_req  = r;
    bus.dma_we   = w;
    bus.dma_addr = ad;
    bus.dma_len  = l;
  endtask

  typedef struct {
    logic cv, cw, req;
    logic [31:0] wd;
    logic gnt, stall, done, wen;
    logic [9:0] addr;
  } vec_t;

  vec_t tbl [6];

  initial begin
    int g, g1, g2, st, nrv, di, gap;
    logic [9:0] wexp [4];
    logic [31:0] wdat [4];
    logic [9:0] rva [$];
    logic pat [6];
    logic [31:0] r;

    tbl[0] = '{1'b0, 1'b0, 1'b1, 32'h0,
               1'b1, 1'b0, 1'b0, 1'b0, 10'h020};
    tbl[1] = '{1'b0, 1'b0, 1'b0, 32'hA0,
               1'b0, 1'b0, 1'b0, 1'b1, 10'h100};
    tbl[2] = '{1'b1, 1'b1, 1'b0, 32'hA1,
               1'b0, 1'b1, 1'b0, 1'b1, 10'h104};
    tbl[3] = '{1'b0, 1'b0, 1'b0, 32'hA2,
               1'b0, 1'b0, 1'b0, 1'b1, 10'h108};
    tbl[4] = '{1'b0, 1'b0, 1'b0, 32'hA3,
               1'b0, 1'b0, 1'b1, 1'b1, 10'h10C};
    tbl[5] = '{1'b1, 1'b0, 1'b0, 32'h0,
               1'b0, 1'b0, 1'b0, 1'b0, 10'h020};

    for (int i = 0; i < 256; i++) mem[i] = $urandom;
    starve = 0;
    set_cpu(1'b1, 1'b1, 10'h0AC);
    set_dma(1'b1, 1'b0, 10'h0, 4'd0);
    bus.cpu_op    = 3'b001;
    bus.cpu_wdata = 32'h1234_5678;
    bus.dma_wdata = 32'h0;

    #2;
    chk("reset_out",
        {bus.dma_gnt, bus.cpu_stall, bus.dma_done,
         bus.mem_w_en, bus.dma_wready, bus.dma_rvalid,
         bus.mem_addr},
        {6'b0, 10'h0AC});
    set_cpu(1'b0, 1'b0, 10'h020);
    set_dma(1'b0, 1'b0, 10'h0, 4'd0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // CPU idle DMA write burst
    for (int i = 0; i < 6; i++) begin
      set_cpu(tbl[i].cv, tbl[i].cw, 10'h020);
      set_dma(tbl[i].req, 1'b1, 10'h100, 4'd3);
      bus.dma_wdata = tbl[i].wd;
      step();
      chk($sformatf("tbl_row%0d", i),
          {o_gnt, o_stall, o_done, o_wen, o_addr},
          {tbl[i].gnt, tbl[i].stall, tbl[i].done,
           tbl[i].wen, tbl[i].addr});
    end
    for (int i = 0; i < 4; i++)
      chk("wr_mem", mem[64 + i], 32'hA0 + 32'(i));

    // starvation
    set_cpu(1'b1, 1'b0, 10'h010);
    set_dma(1'b1, 1'b0, 10'h200, 4'd1);
    g = -1;
    for (int c = 0; c < 12 && g < 0; c++) begin
      step();
      if (o_gnt) g = c;
    end
    chk("starve_gnt_cycle", 64'(g), 64'd4);
    bus.dma_req = 1'b0;
    st = 0;
    for (int c = 0; c < 3; c++) begin
      step();
      st += int'(o_stall);
    end
    chk("starve_stall_cnt", 64'(st), 64'd2);

    // read with address wrap
    wexp = '{10'h3F8, 10'h3FC, 10'h000, 10'h004};
    wdat = '{32'h1111_0001, 32'h2222_0002,
             32'h3333_0003, 32'h4444_0004};
    mem[254] = wdat[0];
    mem[255] = wdat[1];
    mem[0]   = wdat[2];
    mem[1]   = wdat[3];
    set_cpu(1'b0, 1'b0, 10'h010);
    set_dma(1'b1, 1'b0, 10'h3F8, 4'd3);
    step();
    chk("wrap_gnt", 64'(o_gnt), 64'd1);
    bus.dma_req = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("wrap_addr", 64'(o_addr), 64'(wexp[i]));
      chk("wrap_rd", {o_rvalid, o_drdata},
          {1'b1, wdat[i]});
    end

    // en low mid-burst
    pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    set_dma(1'b1, 1'b0, 10'h080, 4'd3);
    step();
    chk("enlow_gnt", 64'(o_gnt), 64'd1);
    bus.dma_req = 1'b0;
    nrv = 0;
    di  = -1;
    rva.delete();
    for (int i = 0; i < 6; i++) begin
      en = pat[i];
      step();
      if (o_rvalid) begin
        nrv++;
        rva.push_back(o_addr);
      end
      if (o_done && di < 0) di = i;
      if (!pat[i])
        chk("enlow_hold", {o_rvalid, o_wen, o_addr},
            {1'b0, 1'b0, 10'h084});
    end
    en = 1'b1;
    chk("enlow_beats", 64'(nrv), 64'd4);
    chk("enlow_done_idx", 64'(di), 64'd5);
    if (rva.size() == 4)
      chk("enlow_addrs",
          {rva[0], rva[1], rva[2], rva[3]},
          {10'h080, 10'h084, 10'h088, 10'h08C});
    else
      chk("enlow_addrs", 64'(rva.size()), 64'd4);

    // reset mid-burst
    set_dma(1'b1, 1'b0, 10'h000, 4'd3);
    step();
    chk("rstb_gnt", 64'(o_gnt), 64'd1);
    bus.dma_req = 1'b0;
    set_cpu(1'b1, 1'b1, 10'h030);
    step();
    step();
    rst = 1'b1;
    #1;
    chk("rst_mid",
        {bus.cpu_stall, bus.dma_done, bus.dma_rvalid,
         bus.dma_gnt, bus.mem_w_en, bus.dma_wready},
        6'b0);
    @(negedge clk);
    rst = 1'b0;
    q.delete();
    starve = 0;
    @(posedge clk);
    #1;
    set_cpu(1'b1, 1'b1, 10'h040);
    bus.cpu_wdata = 32'hDEAD_BEEF;
    step();
    chk("rst_cpu_pass", {o_addr, o_wen, o_stall, o_done},
        {10'h040, 1'b1, 1'b0, 1'b0});
    chk("rst_cpu_wr", mem[16], 32'hDEAD_BEEF);
    set_cpu(1'b1, 1'b0, 10'h100);
    step();
    chk("rst_cpu_rd", o_rdata, 32'hA0);

    // back-to-back requests with CPU busy
    set_cpu(1'b1, 1'b0, 10'h010);
    set_dma(1'b1, 1'b1, 10'h300, 4'd0);
    bus.dma_wdata = 32'h55;
    g1 = -1;
    g2 = -1;
    gap = -1;
    for (int c = 0; c < 20 && g2 < 0; c++) begin
      step();
      if (g1 >= 0 && c == g1 + 2) gap = int'(o_stall);
      if (o_gnt) begin
        if (g1 < 0) g1 = c;
        else g2 = c;
      end
    end
    bus.dma_req = 1'b0;
    chk("b2b_first", 64'(g1), 64'd4);
    chk("b2b_delta", 64'(g2 - g1), 64'd6);
    chk("b2b_gap_stall", 64'(gap), 64'd0);
    step();
    step();

    // randomized traffic
    for (int c = 0; c < 400; c++) begin
      r = $urandom;
      en = r[3:0] != 4'd0;
      set_cpu(r[4], r[5], 10'($urandom));
      bus.cpu_op    = r[8:6];
      bus.cpu_wdata = $urandom;
      r = $urandom;
      set_dma(r[1:0] == 2'b00, r[2],
              r[13:4] & 10'h3FC, r[17:14]);
      bus.dma_wdata = $urandom;
      step();
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
